// File: rtl/cruise_pkg.sv
// Shared types for the cruise speed regulator: FSM states and comparator relation encoding.
package cruise_pkg;

  typedef enum logic [2:0] {
    OFF,
    HOLD,
    ACCEL,
    DECEL,
    FAULT
  } state_t;

  typedef enum logic [1:0] {
    REL_EQ,
    REL_G,
    REL_L
  } rel_t;

  function automatic logic onehot3(input logic [2:0] v);
    return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
  endfunction

endpackage

// File: rtl/relation_persist.sv
// Decodes the comparator G/Eq/L flags and debounces the relation with a
// saturating persistence counter; confirmed reflects the sample being accepted now.
module relation_persist
  import cruise_pkg::*;
#(
  parameter int unsigned PERSIST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic valid,
  input  logic G,
  input  logic Eq,
  input  logic L,
  output rel_t rel,
  output logic confirmed,
  output logic bad_onehot
);

  localparam int unsigned CW = $clog2(PERSIST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(PERSIST);

  rel_t          prev_rel;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;

  always_comb begin
    // Priority decode G > L > Eq; all-zero falls through to Eq.
    rel        = G ? REL_G : (L ? REL_L : REL_EQ);
    bad_onehot = valid && !onehot3({G, Eq, L});
    cnt_n      = cnt;
    if (valid) begin
      if (rel == prev_rel) cnt_n = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      else                 cnt_n = CW'(1);
    end
    confirmed = valid && (cnt_n == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_rel <= REL_EQ;
      cnt      <= '0;
    end else if (clr) begin
      prev_rel <= REL_EQ;
      cnt      <= '0;
    end else if (valid) begin
      prev_rel <= rel;
      cnt      <= cnt_n;
    end
  end

endmodule

// File: rtl/cruise_speed_regulator.sv
// Cruise throttle regulator: debounced speed relation drives an OFF/HOLD/ACCEL/DECEL FSM.
// Define CMP_ONEHOT_CHECK_EN to trap non-one-hot comparator samples into a sticky FAULT state.
module cruise_speed_regulator
  import cruise_pkg::*;
#(
  parameter int unsigned THR_W   = 8,
  parameter int unsigned STEP    = 1,
  parameter int unsigned THR_MAX = 255,
  parameter int unsigned PERSIST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             brake,
  input  logic             cmp_valid,
  input  logic             G,
  input  logic             Eq,
  input  logic             L,
  input  logic [THR_W-1:0] throttle_init,
  output logic [THR_W-1:0] throttle,
  output logic             accel,
  output logic             decel,
  output logic             fault
);

  localparam logic [THR_W:0]   STEP_X = (THR_W + 1)'(STEP);
  localparam logic [THR_W:0]   MAX_X  = (THR_W + 1)'(THR_MAX);
  localparam logic [THR_W-1:0] STEP_T = THR_W'(STEP);
  localparam logic [THR_W-1:0] MAX_T  = THR_W'(THR_MAX);

  state_t           state, state_n;
  logic [THR_W-1:0] thr_n, thr_up, thr_dn, thr_init_clip;
  logic [THR_W:0]   thr_sum;
  logic             kill;
  rel_t             rel;
  logic             confirmed, bad_onehot, bad_go;

  assign kill = brake | ~enable;

  relation_persist #(.PERSIST(PERSIST)) u_persist (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (kill),
    .valid     (cmp_valid),
    .G         (G),
    .Eq        (Eq),
    .L         (L),
    .rel       (rel),
    .confirmed (confirmed),
    .bad_onehot(bad_onehot)
  );

`ifdef CMP_ONEHOT_CHECK_EN
  assign bad_go = bad_onehot;
`else
  logic cmp_unused;
  assign cmp_unused = bad_onehot;
  assign bad_go     = 1'b0;
`endif

  always_comb begin
    thr_sum       = {1'b0, throttle} + STEP_X;
    thr_up        = (thr_sum > MAX_X) ? MAX_T : thr_sum[THR_W-1:0];
    thr_dn        = ({1'b0, throttle} < STEP_X) ? '0 : throttle - STEP_T;
    thr_init_clip = ({1'b0, throttle_init} > MAX_X) ? MAX_T : throttle_init;
  end

  always_comb begin
    state_n = state;
    thr_n   = throttle;
    if (kill) begin
      state_n = OFF;
      thr_n   = '0;
    end else begin
      unique case (state)
        OFF: begin
          state_n = HOLD;
          thr_n   = thr_init_clip;
        end
        HOLD: begin
          if (bad_go) begin
            state_n = FAULT;
            thr_n   = '0;
          end else if (confirmed && rel == REL_L) state_n = ACCEL;
          else if (confirmed && rel == REL_G)     state_n = DECEL;
        end
        ACCEL: begin
          if (bad_go) begin
            state_n = FAULT;
            thr_n   = '0;
          end else if (cmp_valid) begin
            if (rel == REL_L) thr_n = thr_up;
            else              state_n = HOLD;
          end
        end
        DECEL: begin
          if (bad_go) begin
            state_n = FAULT;
            thr_n   = '0;
          end else if (cmp_valid) begin
            if (rel == REL_G) thr_n = thr_dn;
            else              state_n = HOLD;
          end
        end
        FAULT: thr_n = '0;
        default: begin
          state_n = OFF;
          thr_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OFF;
      throttle <= '0;
      accel    <= 1'b0;
      decel    <= 1'b0;
    end else begin
      state    <= state_n;
      throttle <= thr_n;
      accel    <= (state_n == ACCEL);
      decel    <= (state_n == DECEL);
    end
  end

`ifdef CMP_ONEHOT_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault <= 1'b0;
    else        fault <= (state_n == FAULT);
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_cruise_speed_regulator.sv
// Scoreboard bench for cruise_speed_regulator: expected outputs queued at drive time, checked after the edge.
module tb_cruise_speed_regulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, brake, cmp_valid, G, Eq, L;
  logic [7:0] throttle_init;
  logic [7:0] throttle;
  logic       accel, decel, fault;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  logic [10:0] sb_q[$];

  localparam logic [2:0] S_L   = 3'b001;
  localparam logic [2:0] S_EQ  = 3'b010;
  localparam logic [2:0] S_G   = 3'b100;
  localparam logic [2:0] S_BAD = 3'b101;

  cruise_speed_regulator #(
    .THR_W  (8),
    .STEP   (1),
    .THR_MAX(255),
    .PERSIST(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .brake        (brake),
    .cmp_valid    (cmp_valid),
    .G            (G),
    .Eq           (Eq),
    .L            (L),
    .throttle_init(throttle_init),
    .throttle     (throttle),
    .accel        (accel),
    .decel        (decel),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {fault,decel,accel,thr}=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected registered response, then check it.
  task automatic cyc(input logic en, input logic br, input logic v, input logic [2:0] gel,
                     input logic [7:0] init, input logic [7:0] et, input logic ea,
                     input logic ed, input logic ef, input string tag);
    logic [10:0] exp_v;
    @(negedge clk);
    enable        = en;
    brake         = br;
    cmp_valid     = v;
    {G, Eq, L}    = gel;
    throttle_init = init;
    sb_q.push_back({ef, ed, ea, et});
    @(posedge clk);
    #1;
    exp_v = sb_q.pop_front();
    check_eq(tag, {fault, decel, accel, throttle}, exp_v);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; brake = 1'b0; cmp_valid = 1'b0;
    G = 1'b0; Eq = 1'b0; L = 1'b0; throttle_init = 8'd0;
    #12;
    check_eq("reset", {fault, decel, accel, throttle}, 11'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: engage, confirm L, ramp
    cyc(1, 0, 0, S_EQ, 100, 100, 0, 0, 0, "engage");
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, S_L, 100, 100, 0, 0, 0, "persist_l");
    cyc(1, 0, 1, S_L, 100, 100, 1, 0, 0, "enter_accel");
    for (int k = 1; k <= 3; k++) cyc(1, 0, 1, S_L, 100, 8'(100 + k), 1, 0, 0, "accel_step");

    // 2: ramp to ceiling and saturate
    for (int k = 1; k <= 151; k++) cyc(1, 0, 1, S_L, 100, 8'(103 + k), 1, 0, 0, "accel_ramp");
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, S_L, 100, 255, 1, 0, 0, "accel_sat");
    cyc(1, 0, 1, S_EQ, 100, 255, 0, 0, 0, "accel_to_hold");

    // 3: interrupted G run stays in HOLD, then DECEL to floor
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, S_G, 100, 255, 0, 0, 0, "hold_g");
    cyc(1, 0, 1, S_L, 100, 255, 0, 0, 0, "hold_l_break");
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, S_G, 100, 255, 0, 0, 0, "hold_g2");
    cyc(1, 0, 1, S_G, 100, 255, 0, 1, 0, "enter_decel");
    for (int k = 1; k <= 254; k++) cyc(1, 0, 1, S_G, 100, 8'(255 - k), 0, 1, 0, "decel_ramp");
    cyc(1, 0, 1, S_G, 100, 0, 0, 1, 0, "decel_floor0");
    cyc(1, 0, 1, S_G, 100, 0, 0, 1, 0, "decel_floor1");

    // 4: brake mid-DECEL at 50, then release
    cyc(1, 1, 0, S_EQ, 53, 0, 0, 0, 0, "brake_off");
    cyc(1, 0, 0, S_EQ, 53, 53, 0, 0, 0, "reengage");
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, S_G, 53, 53, 0, 0, 0, "persist_g");
    cyc(1, 0, 1, S_G, 53, 53, 0, 1, 0, "enter_decel2");
    for (int k = 1; k <= 3; k++) cyc(1, 0, 1, S_G, 53, 8'(53 - k), 0, 1, 0, "decel_to50");
    cyc(1, 1, 1, S_G, 53, 0, 0, 0, 0, "brake_mid_decel");
    cyc(1, 0, 0, S_EQ, 77, 77, 0, 0, 0, "brake_release");

    // 5: non-one-hot sample
`ifdef CMP_ONEHOT_CHECK_EN
    cyc(1, 0, 1, S_BAD, 77, 0, 0, 0, 1, "bad_onehot_fault");
    cyc(1, 0, 1, S_EQ, 77, 0, 0, 0, 1, "fault_sticky");
`else
    cyc(1, 0, 1, S_BAD, 77, 77, 0, 0, 0, "bad_as_g");
    cyc(1, 0, 1, S_EQ, 77, 77, 0, 0, 0, "after_bad");
`endif
    cyc(0, 0, 0, S_EQ, 77, 0, 0, 0, 0, "disable_off");

    // 6: async reset mid-ACCEL at 120
    cyc(1, 0, 0, S_EQ, 116, 116, 0, 0, 0, "engage3");
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, S_L, 116, 116, 0, 0, 0, "persist_l3");
    cyc(1, 0, 1, S_L, 116, 116, 1, 0, 0, "enter_accel3");
    for (int k = 1; k <= 4; k++) cyc(1, 0, 1, S_L, 116, 8'(116 + k), 1, 0, 0, "accel_to120");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_eq("async_reset", {fault, decel, accel, throttle}, 11'd0);
    @(negedge clk);
    enable = 1'b0; cmp_valid = 1'b0;
    rst_n = 1'b1;
    cyc(1, 0, 0, S_EQ, 5, 5, 0, 0, 0, "post_reset_engage");
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, S_L, 5, 5, 0, 0, 0, "post_reset_count");
    cyc(1, 0, 1, S_L, 5, 5, 1, 0, 0, "post_reset_accel");
    cyc(1, 0, 1, S_L, 5, 6, 1, 0, 0, "post_reset_step");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
